// File: rtl/alu_share_arb.sv
// Shares one combinational RV32I alu between two requesters. Round-robin grant, or fixed priority when ALU_ARB_FIXED_PRIO_EN is defined.
// Operands latch on accept, the alu runs in the next cycle, and the registered result is held on rsp_* until rsp_ready.

module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_op,
   output logic [31:0] alu_res
);
   always_comb begin
      alu_res = '0;
      case (alu_op)
         4'b0000: alu_res = a + b;
         4'b1000: alu_res = a - b;
         4'b0001: alu_res = a << b[4:0];
         4'b0010: alu_res = {31'd0, $signed(a) < $signed(b)};
         4'b0011: alu_res = {31'd0, a < b};
         4'b0100: alu_res = a ^ b;
         4'b0101: alu_res = a >> b[4:0];
         4'b1101: alu_res = $unsigned($signed(a) >>> b[4:0]);
         4'b0110: alu_res = a | b;
         4'b0111: alu_res = a & b;
         4'b1001: alu_res = b;
         default: alu_res = '0;
      endcase
   end
endmodule

module alu_share_arb #(
   parameter int XLEN = 32,
   parameter int OPW  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic [OPW-1:0]  req0_op,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   input  logic [OPW-1:0]  req1_op,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_res,
   output logic            rsp_id,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state, state_nxt;
   logic            run;
   logic [XLEN-1:0] op_a, op_b;
   logic [OPW-1:0]  op_code;
   logic            id;
   logic            grant0, grant1;
   logic [XLEN-1:0] alu_res;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant0 = req0_valid;
   assign grant1 = req1_valid && !req0_valid;
`else
   logic last_grant;
   // On a tie the requester that did not win last time goes first.
   assign grant0 = req0_valid && (!req1_valid || last_grant);
   assign grant1 = req1_valid && (!req0_valid || !last_grant);
`endif

   alu u_alu (
      .a       (op_a),
      .b       (op_b),
      .alu_op  (op_code),
      .alu_res (alu_res)
   );

   // run keeps both readies low while in reset and for the first cycle after release.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = run && grant0;
            req1_ready = run && grant1;
            if (req0_ready || req1_ready) state_nxt = EXEC;
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         run       <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_code   <= '0;
         id        <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_res   <= '0;
         rsp_id    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         run   <= 1'b1;
         case (state)
            IDLE: begin
               if (req0_ready) begin
                  op_a    <= req0_a;
                  op_b    <= req0_b;
                  op_code <= req0_op;
                  id      <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last_grant <= 1'b0;
`endif
               end else if (req1_ready) begin
                  op_a    <= req1_a;
                  op_b    <= req1_b;
                  op_code <= req1_op;
                  id      <= 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last_grant <= 1'b1;
`endif
               end
            end
            EXEC: begin
               rsp_res   <= alu_res;
               rsp_id    <= id;
               rsp_valid <= 1'b1;
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb; expectations are hand-computed.
`timescale 1ns/1ps
module tb_alu_share_arb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [31:0] rsp_res;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_share_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res), .rsp_id(rsp_id), .busy(busy)
   );

   task automatic test_reset;
      rst_n = 1'b0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
      req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      repeat (2) @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_res !== 32'd0) begin errors++; $display("FAIL reset_rsp_res got=%h exp=0", rsp_res); end
      checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // One isolated operation from requester 'who'; checks handshake, latency and result.
   task automatic single_op(input string name, input bit who, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] exp);
      if (who) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
      else     begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
      rsp_ready = 1;
      #1;
      checks++; if ({req1_ready, req0_ready} !== (who ? 2'b10 : 2'b01)) begin errors++;
         $display("FAIL %s_ready got=%b exp=%b", name, {req1_ready, req0_ready}, who ? 2'b10 : 2'b01); end
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #1;
      checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
         $display("FAIL %s_exec busy=%b rsp_valid=%b exp busy=1 rsp_valid=0", name, busy, rsp_valid); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_res !== exp || rsp_id !== who) begin errors++;
         $display("FAIL %s_rsp valid=%b res=%h id=%b exp valid=1 res=%h id=%b", name, rsp_valid, rsp_res, rsp_id, exp, who); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL %s_retire rsp_valid=%b busy=%b exp 0 0", name, rsp_valid, busy); end
   endtask

   task automatic test_req0_only;
      single_op("add0", 1'b0, 32'd10, 32'd5, 4'b0000, 32'd15);
   endtask

   task automatic test_req1_only;
      single_op("sub1", 1'b1, 32'd10, 32'd20, 4'b1000, 32'hFFFF_FFF6);
      single_op("sra1", 1'b1, 32'hFFFF_FFC0, 32'd3, 4'b1101, 32'hFFFF_FFF8);
   endtask

   task automatic test_back_to_back;
      int n;
      logic exp_id;
      logic [31:0] exp_res;
      n = 0;
      rsp_ready = 1;
      req0_valid = 1; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0F0F_0F0F; req0_op = 4'b0100;
      req1_valid = 1; req1_a = 32'hFFFF_0000; req1_b = 32'h00FF_00FF; req1_op = 4'b0111;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = n[0];
`endif
            exp_res = exp_id ? 32'h00FF_0000 : 32'hFFFF_FFFF;
            checks++; if (rsp_id !== exp_id || rsp_res !== exp_res) begin errors++;
               $display("FAIL b2b_rsp%0d id=%b res=%h exp id=%b res=%h", n, rsp_id, rsp_res, exp_id, exp_res); end
            n++;
         end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", n); end
      req0_valid = 0; req1_valid = 0;
      // Drain any in-flight operation.
      for (int i = 0; i < 10 && busy; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      rsp_ready = 0;
      req0_valid = 1; req0_a = 32'hFFFF_FFFB; req0_b = 32'd3; req0_op = 4'b0010;
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 4'b0000;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_res !== 32'd1 || rsp_id !== 1'b0 || busy !== 1'b1 ||
                       req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
            $display("FAIL bp_hold%0d valid=%b res=%h id=%b busy=%b rdy=%b%b exp 1 00000001 0 1 00", i,
                     rsp_valid, rsp_res, rsp_id, busy, req0_ready, req1_ready); end
         @(negedge clk);
      end
      req1_valid = 0;
      rsp_ready = 1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL bp_retire valid=%b busy=%b exp 0 0", rsp_valid, busy); end
   endtask

   task automatic test_operand_hazard;
      rsp_ready = 1;
      req0_valid = 1; req0_a = 32'hAAAA_0000; req0_b = 32'h0000_BBBB; req0_op = 4'b0110;
      @(negedge clk);
      req0_valid = 0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'b1000;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_res !== 32'hAAAA_BBBB) begin errors++;
         $display("FAIL hazard_res valid=%b res=%h exp 1 aaaabbbb", rsp_valid, rsp_res); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit seen_rsp;
      bit granted;
      seen_rsp = 0; granted = 0;
      rsp_ready = 1;
      req0_valid = 1; req0_a = 32'd7; req0_b = 32'd8; req0_op = 4'b0000;
      req1_valid = 1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b0000;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_exec busy=%b exp=1", busy); end
      rst_n = 0;
      #1;
      checks++; if (rsp_valid !== 0 || rsp_res !== 0 || rsp_id !== 0 || busy !== 0 || req0_ready !== 0 || req1_ready !== 0) begin
         errors++; $display("FAIL midrst_outs valid=%b res=%h id=%b busy=%b rdy=%b%b exp all 0",
                            rsp_valid, rsp_res, rsp_id, busy, req0_ready, req1_ready); end
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid) seen_rsp = 1; end
      rst_n = 1;
      for (int i = 0; i < 10 && !granted; i++) begin
         if (rsp_valid) seen_rsp = 1;
         if (req0_ready || req1_ready) granted = 1; else @(negedge clk);
      end
      checks++; if (seen_rsp) begin errors++; $display("FAIL midrst_no_rsp got=1 exp=0"); end
      checks++; if (!granted || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
         $display("FAIL midrst_first_grant granted=%0d rdy0=%b rdy1=%b exp 1 1 0", granted, req0_ready, req1_ready); end
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'd15) begin errors++;
         $display("FAIL midrst_rsp valid=%b id=%b res=%h exp 1 0 0000000f", rsp_valid, rsp_id, rsp_res); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_req0_only();
      test_req1_only();
      test_back_to_back();
      test_backpressure();
      test_operand_hazard();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
